apb_uart_tx: RTL and testbench
==============================

// Module: apb_uart_tx
// PURPOSE
// - APB subordinate UART transmitter: the responder end of the core APB manager, and the TX-only serial end.
// - Sits on a free APB demux port beside the mtimer; tx_o drives the board TX pin; irq_o goes to an ext_irqs line.
// - Buffers bytes in a FIFO and serialises them as 8N1 frames, LSB first, at a programmable bit period.
// PARAMETERS
// - FifoDepth  8       TX FIFO entries; power of 2, >=2
// - DivReset   16'd433 DIV reset value; bit period = DIV+1 clk cycles
// - DataWidth  32      APB data width
// PORTS
// - clk_i      in   1   clock
// - rst_ni     in   1   reset, asynchronous, active-high
// - psel_i     in   1   APB select
// - penable_i  in   1   APB enable
// - pwrite_i   in   1   APB write
// - paddr_i    in   32  APB address; only [3:2] decoded
// - pwdata_i   in   32  APB write data
// - prdata_o   out  32  APB read data
// - pready_o   out  1   APB ready; constant 1
// - pslverr_o  out  1   APB error
// - tx_o       out  1   serial out; idle high
// - irq_o      out  1   level IRQ, TX drained
// BEHAVIOUR
// - Reset values: prdata_o=0, pslverr_o=0, tx_o=1, irq_o=0, FIFO empty, DIV=DivReset, CTRL=0, FSM IDLE.
// - APB: zero wait states. Access completes on psel_i&penable_i. Side effects occur in that cycle only.
// - pslverr_o and prdata_o are combinational, valid in the access cycle, and 0 otherwise.
// - Register map (offset -> register):
//   0x0 TXDATA  W: push pwdata[7:0]. Push while full sets pslverr=1 and drops the byte. Reads return 0.
//   0x4 STATUS  R: [0] busy (FSM!=IDLE), [1] full, [2] empty, [15:8] FIFO level. Writes are ignored.
//   0x8 DIV     RW [15:0]. Upper bits read 0.
//   0xC CTRL    RW [0] tx_en, [1] irq_en.
// - Full is evaluated on the pre-cycle count: a push while full errors even if the FSM pops in the same cycle.
// - FSM states: IDLE, START, DATA, STOP.
//   IDLE->START when tx_en=1 and FIFO not empty. The FIFO pops in that cycle and the byte goes to the shift register.
//   START: tx_o=0 for DIV+1 cycles -> DATA.
//   DATA: 8 bits LSB first, each DIV+1 cycles; a 3-bit counter tracks the bit; after bit 7 -> STOP.
//   STOP: tx_o=1 for DIV+1 cycles. Then START directly if tx_en=1 and FIFO not empty (back-to-back, no idle gap); else IDLE.
// - Bit counter: down-counter loaded with DIV at each bit boundary. A DIV write mid-frame takes effect at the next boundary.
//   DIV=0 is legal and gives 1 cycle per bit.
// - tx_o is registered; the first start-bit cycle is the cycle after the IDLE->START pop.
// - tx_en cleared mid-frame: the current frame completes; FIFO contents are retained and no new frame starts.
// - irq_o = irq_en & empty & (state==IDLE), registered with 1-cycle latency.
// - Reset mid-frame: tx_o returns high immediately (async); FIFO contents are lost.
// - FIFO pointers wrap modulo FifoDepth. The level counter is $clog2(FifoDepth)+1 bits wide and never exceeds FifoDepth.
// STRUCTURE
// - zeroheti_pkg additions: UartTxDataOff/UartTxStatusOff/UartTxDivOff/UartTxCtrlOff offset constants,
//   uart_tx_state_e enum, and the AddrMap entry for the uart_tx range.
// - One sub-module: zeroheti_sync_fifo (parametric width/depth; push/pop/full/empty/level; no bypass).
// - Top: APB decode plus registers, FIFO instance, and the TX FSM with bit and baud counters.
// TESTING
// - Reset: tx_o=1, irq_o=0; STATUS read=0x0000_0004; DIV read=433 (DivReset).
// - DIV=3, CTRL=1, write 0xA5 -> tx_o=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1; frame is 40 cycles.
// - Write 9 bytes with CTRL=0, FifoDepth=8 -> writes 1-8 give pslverr=0; 9th gives pslverr=1; STATUS=0x0000_0802.
// - CTRL=3, two bytes queued, DIV=0 -> two 10-cycle frames with no idle gap; irq_o rises 1 cycle after FSM returns to IDLE.
// - DIV changed 3->7 mid-DATA -> current bit stays 4 cycles; following bits are 8 cycles each.
// - rst_ni asserted mid-DATA -> tx_o=1 in the same cycle; after release STATUS=0x0000_0004.

Source files
------------

// File: rtl/zeroheti_pkg.sv
// Shared zeroheti SoC definitions: UART TX register offsets, FSM state type and address-map entry.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] last;
  } addr_rule_t;

  // UART TX occupies a 16-byte window on a free APB demux port next to the mtimer.
  localparam addr_rule_t AddrMapUartTx = '{base: 32'h0003_0100, last: 32'h0003_010F};

  localparam logic [3:0] UartTxDataOff   = 4'h0;
  localparam logic [3:0] UartTxStatusOff = 4'h4;
  localparam logic [3:0] UartTxDivOff    = 4'h8;
  localparam logic [3:0] UartTxCtrlOff   = 4'hC;

  typedef enum logic [1:0] {
    UartTxIdle,
    UartTxStart,
    UartTxData,
    UartTxStop
  } uart_tx_state_e;

endpackage

// File: rtl/zeroheti_sync_fifo.sv
// Single-clock FIFO with level counter; head entry visible on rdata_o, no write-to-read bypass.
module zeroheti_sync_fifo #(
  parameter  int unsigned Width = 8,
  parameter  int unsigned Depth = 8,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned LvlW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: storage has no reset; only pointers and level define validity, and a
  // resettable array would cost a flop-based reset tree for no functional gain.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // rst_ni is active-high here despite its name, matching the rest of the codebase.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/apb_uart_tx.sv
// APB subordinate UART transmitter: FIFO-buffered 8N1 serialiser with programmable bit period.
module apb_uart_tx
  import zeroheti_pkg::*;
#(
  parameter int unsigned FifoDepth = 8,
  parameter logic [15:0] DivReset  = 16'd433,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 tx_o,
  output logic                 irq_o
);

  localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

  logic            access, wr_acc, rd_acc;
  logic            sel_data, sel_status, sel_div, sel_ctrl;
  logic [15:0]     div_q;
  logic            tx_en_q, irq_en_q;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [LvlW-1:0] fifo_level;

  uart_tx_state_e state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           irq_q;
  logic           start_ok;

  logic unused_bits;
  assign unused_bits = ^{paddr_i[31:4], paddr_i[1:0], pwdata_i[DataWidth-1:16]};

  assign access     = psel_i & penable_i;
  assign wr_acc     = access & pwrite_i;
  assign rd_acc     = access & ~pwrite_i;
  assign sel_data   = (paddr_i[3:2] == UartTxDataOff[3:2]);
  assign sel_status = (paddr_i[3:2] == UartTxStatusOff[3:2]);
  assign sel_div    = (paddr_i[3:2] == UartTxDivOff[3:2]);
  assign sel_ctrl   = (paddr_i[3:2] == UartTxCtrlOff[3:2]);

  // Full is the registered pre-cycle state, so a same-cycle pop cannot rescue a push.
  assign fifo_push = wr_acc & sel_data & ~fifo_full;
  assign pslverr_o = wr_acc & sel_data & fifo_full;
  assign pready_o  = 1'b1;

  always_comb begin
    prdata_o = '0;
    if (rd_acc) begin
      if (sel_status) begin
        prdata_o[0]    = (state_q != UartTxIdle);
        prdata_o[1]    = fifo_full;
        prdata_o[2]    = fifo_empty;
        prdata_o[15:8] = 8'(fifo_level);
      end else if (sel_div) begin
        prdata_o[15:0] = div_q;
      end else if (sel_ctrl) begin
        prdata_o[1:0] = {irq_en_q, tx_en_q};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      div_q    <= DivReset;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr_acc) begin
      if (sel_div)  div_q <= pwdata_i[15:0];
      if (sel_ctrl) {irq_en_q, tx_en_q} <= pwdata_i[1:0];
    end
  end

  zeroheti_sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (pwdata_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign start_ok = tx_en_q & ~fifo_empty;

  // The baud counter reloads from DIV only at bit boundaries, so DIV writes apply from the next bit.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      UartTxIdle: begin
        if (start_ok) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = div_q;
          tx_d     = 1'b0;
          state_d  = UartTxStart;
        end
      end
      UartTxStart: begin
        if (baud_q == '0) begin
          baud_d  = div_q;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = UartTxData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      UartTxData: begin
        if (baud_q == '0) begin
          baud_d = div_q;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = UartTxStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      UartTxStop: begin
        if (baud_q == '0) begin
          if (start_ok) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            baud_d   = div_q;
            tx_d     = 1'b0;
            state_d  = UartTxStart;
          end else begin
            state_d = UartTxIdle;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = UartTxIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q <= UartTxIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_en_q & fifo_empty & (state_q == UartTxIdle);
    end
  end

  assign tx_o  = tx_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: register map, frame timing, back-to-back frames, DIV change and reset.
module tb_apb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr, tx, irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_uart_tx dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .tx_o      (tx),
    .irq_o     (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Two-phase APB access; returns just after the completing rising edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rdata = prdata;
    err   = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
  endtask

  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic [31:0] rd;
  logic        err;
  logic [9:0]  f1;
  logic [19:0] f2;

  initial begin
    rst_ni = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("idle_prdata", prdata, 32'd0);
    check("idle_pslverr", {31'd0, pslverr}, 32'd0);
    check("pready", {31'd0, pready}, 32'd1);
    apb_xfer(1'b0, 32'h4, 32'd0, rd, err);
    check("rst_status", rd, 32'h0000_0004);
    apb_xfer(1'b0, 32'h8, 32'd0, rd, err);
    check("rst_div", rd, 32'd433);
    apb_xfer(1'b0, 32'h0, 32'd0, rd, err);
    check("txdata_read", rd, 32'd0);

    // Single 0xA5 frame at DIV=3: 10 bits of 4 cycles each.
    apb_xfer(1'b1, 32'h8, 32'hDEAD_0003, rd, err);
    apb_xfer(1'b0, 32'h8, 32'd0, rd, err);
    check("div_upper_zero", rd, 32'd3);
    apb_xfer(1'b1, 32'hC, 32'd1, rd, err);
    apb_xfer(1'b0, 32'hC, 32'd0, rd, err);
    check("ctrl_read", rd, 32'd1);
    apb_xfer(1'b1, 32'h0, 32'h0000_00A5, rd, err);
    check("push_a5_err", {31'd0, err}, 32'd0);
    f1 = frame_bits(8'hA5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("a5_cyc%0d", i), {31'd0, tx}, {31'd0, f1[i/4]});
    end
    apb_xfer(1'b0, 32'h4, 32'd0, rd, err);
    check("a5_done_status", rd, 32'h0000_0004);

    // Fill past capacity with transmit disabled.
    apb_xfer(1'b1, 32'hC, 32'd0, rd, err);
    for (int i = 0; i < 9; i++) begin
      apb_xfer(1'b1, 32'h0, 32'(i), rd, err);
      check($sformatf("fill_err%0d", i), {31'd0, err}, (i == 8) ? 32'd1 : 32'd0);
    end
    apb_xfer(1'b0, 32'h4, 32'd0, rd, err);
    check("full_status", rd, 32'h0000_0802);
    check("full_tx_idle", {31'd0, tx}, 32'd1);

    // Back-to-back frames at DIV=0, then drained IRQ.
    do_reset();
    apb_xfer(1'b1, 32'h8, 32'd0, rd, err);
    apb_xfer(1'b1, 32'h0, 32'h3C, rd, err);
    apb_xfer(1'b1, 32'h0, 32'hC3, rd, err);
    apb_xfer(1'b0, 32'h4, 32'd0, rd, err);
    check("two_queued_status", rd, 32'h0000_0200);
    apb_xfer(1'b1, 32'hC, 32'd3, rd, err);
    f2 = {frame_bits(8'hC3), frame_bits(8'h3C)};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_cyc%0d", i), {31'd0, tx}, {31'd0, f2[i]});
      if (i == 15) check("b2b_irq_low", {31'd0, irq}, 32'd0);
    end
    @(posedge clk); #1;
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    check("post_b2b_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, irq}, 32'd1);

    // DIV 3 -> 7 written during data bit 0 of 0x55.
    apb_xfer(1'b1, 32'h8, 32'd3, rd, err);
    apb_xfer(1'b1, 32'h0, 32'h55, rd, err);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("div_chg_pre%0d", i), {31'd0, tx}, (i <= 4) ? 32'd0 : 32'd1);
    end
    apb_xfer(1'b1, 32'h8, 32'd7, rd, err);
    check("div_chg_bit0_end", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check($sformatf("div_chg_slow%0d", i), {31'd0, tx}, (i < 8) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    check("div_chg_bit3", {31'd0, tx}, 32'd0);

    // Asynchronous reset mid-frame while tx is low.
    #2;
    rst_ni = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    apb_xfer(1'b0, 32'h4, 32'd0, rd, err);
    check("post_rst_status", rd, 32'h0000_0004);
    apb_xfer(1'b0, 32'h8, 32'd0, rd, err);
    check("post_rst_div", rd, 32'd433);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
